tone_sequencer: RTL and testbench

//  Sequences the tone datapath: requests a random frequency, presents it to the

---
 rtl/tone_sequencer_pkg.sv | 23 ++
 rtl/tone_sequencer_period_timer.sv | 29 ++
 rtl/tone_sequencer.sv | 134 +++++++++++++
 tb/tb_tone_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_sequencer_pkg.sv
// tone_sequencer_pkg: shared state encodings, default widths/limits and timer sizing
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_TONE = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    localparam int FREQ_W_DEF   = 12;
    localparam int FREQ_MIN_DEF = 100;
    localparam int FREQ_MAX_DEF = 3000;
    localparam int CLK_HZ       = 16_000_000;

    function automatic int timer_w(input int tone, input int gap);
        int m;
        m = tone > gap ? tone : gap;
        m = m < 2 ? 2 : m;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/tone_sequencer_period_timer.sv
// tone_sequencer_period_timer: loadable down-counter with zero flag, shared by tone and gap
module tone_sequencer_period_timer
    import tone_sequencer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // load wins over decrement; the count parks at zero
    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    // counter register, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    assign cnt_o  = cnt_q;
    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: requests a random frequency, plays it for a tone period, then a gap, until stopped
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int TONE_CYC = 16_000_000,
    parameter int GAP_CYC  = 0,
    parameter int FREQ_MIN = FREQ_MIN_DEF,
    parameter int FREQ_MAX = FREQ_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              rnd_valid,
    input  logic [FREQ_W-1:0] rnd_freq,
    output logic              rnd_req,
    output logic [FREQ_W-1:0] freq_out,
    output logic              tone_en,
    output logic              sec,
    output logic              busy,
    output logic [7:0]        tone_cnt
);

    localparam int              TW      = timer_w(TONE_CYC, GAP_CYC);
    localparam logic [TW-1:0]   TONE_LD = TW'(TONE_CYC - 1);
    localparam logic [TW-1:0]   GAP_LD  = TW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
    localparam logic [FREQ_W-1:0] FMIN  = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] FMAX  = FREQ_W'(FREQ_MAX);

    state_e            state_q;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              tone_en_q, rnd_req_q, sec_q, sec_d, busy_q, stop_pend_q;
    logic [7:0]        tone_cnt_q;
    logic [TW-1:0]     tmr_cnt, tmr_val;
    logic              tmr_zero, tmr_load, tmr_dec, hs, pend;

    // handshake, clamp, timer control and the sec look-ahead
    always_comb begin
        hs       = state_q == S_REQ && rnd_req_q && rnd_valid && !stop;
        pend     = stop_pend_q || stop;
        freq_d   = rnd_freq < FMIN ? FMIN : rnd_freq > FMAX ? FMAX : rnd_freq;
        tmr_load = hs || (state_q == S_TONE && tmr_zero && GAP_CYC > 0);
        tmr_val  = hs ? TONE_LD : GAP_LD;
        tmr_dec  = state_q == S_TONE || state_q == S_GAP;
        sec_d    = (hs && TONE_CYC == 1) || (state_q == S_TONE && tmr_cnt == TW'(1));
    end

    tone_sequencer_period_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .dec_i  (tmr_dec),
        .cnt_o  (tmr_cnt),
        .zero_o (tmr_zero)
    );

    // sequencing FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            freq_q      <= '0;
            tone_en_q   <= 1'b0;
            rnd_req_q   <= 1'b0;
            sec_q       <= 1'b0;
            busy_q      <= 1'b0;
            tone_cnt_q  <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            sec_q <= sec_d;
            case (state_q)
                S_IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (start && !stop) begin
                        state_q   <= S_REQ;
                        rnd_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (stop) begin
                        state_q   <= S_IDLE;
                        rnd_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (hs) begin
                        state_q   <= S_TONE;
                        freq_q    <= freq_d;
                        tone_en_q <= 1'b1;
                        rnd_req_q <= 1'b0;
                    end
                end
                S_TONE: begin
                    if (stop) stop_pend_q <= 1'b1;
                    if (tmr_zero) begin
                        tone_cnt_q <= tone_cnt_q + 8'd1;
                        tone_en_q  <= 1'b0;
                        if (GAP_CYC > 0) begin
                            state_q <= S_GAP;
                        end else if (pend) begin
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                        end else begin
                            state_q   <= S_REQ;
                            rnd_req_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (stop) stop_pend_q <= 1'b1;
                    if (tmr_zero) begin
                        if (pend) begin
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                        end else begin
                            state_q   <= S_REQ;
                            rnd_req_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rnd_req  = rnd_req_q;
    assign freq_out = freq_q;
    assign tone_en  = tone_en_q;
    assign sec      = sec_q;
    assign busy     = busy_q;
    assign tone_cnt = tone_cnt_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scoreboard bench for a gapped build (A) and a back-to-back build (B)
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, start_a = 1'b0, stop_a = 1'b0, rnd_valid_a = 1'b0;
    logic [11:0] rnd_freq_a = '0;
    logic        rnd_req_a, tone_en_a, sec_a, busy_a;
    logic [11:0] freq_out_a;
    logic [7:0]  tone_cnt_a;
    logic        rst_b = 1'b1, start_b = 1'b0, stop_b = 1'b0, rnd_valid_b = 1'b0;
    logic [11:0] rnd_freq_b = '0;
    logic        rnd_req_b, tone_en_b, sec_b, busy_b;
    logic [11:0] freq_out_b;
    logic [7:0]  tone_cnt_b;

    typedef struct { int f; int c; } exp_t;
    exp_t sbq[$];
    exp_t e_m;
    int   n_chk = 0, n_pass = 0, cnt_a = 0, cnt_exp_m = 0;
    bit   cnt_due = 0;

    always #5 clk = ~clk;

    tone_sequencer #(.FREQ_W(12), .TONE_CYC(8), .GAP_CYC(2), .FREQ_MIN(100), .FREQ_MAX(3000)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .stop(stop_a), .rnd_valid(rnd_valid_a),
        .rnd_freq(rnd_freq_a), .rnd_req(rnd_req_a), .freq_out(freq_out_a), .tone_en(tone_en_a),
        .sec(sec_a), .busy(busy_a), .tone_cnt(tone_cnt_a)
    );

    tone_sequencer #(.FREQ_W(12), .TONE_CYC(8), .GAP_CYC(0), .FREQ_MIN(100), .FREQ_MAX(3000)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b), .rnd_valid(rnd_valid_b),
        .rnd_freq(rnd_freq_b), .rnd_req(rnd_req_b), .freq_out(freq_out_b), .tone_en(tone_en_b),
        .sec(sec_b), .busy(busy_b), .tone_cnt(tone_cnt_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // wait for rnd_req, present a frequency and expect its clamped value
    task automatic accept(input int f, input int ef);
        int w = 0;
        rnd_valid_a = 1'b1;
        rnd_freq_a  = 12'(f);
        while (!rnd_req_a && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_wait", int'(w < 50), 1);
        cnt_a++;
        sbq.push_back('{ef, cnt_a % 256});
        @(negedge clk);
        rnd_valid_a = 1'b0;
        chk("hs_req_drop", int'(rnd_req_a), 0);
        chk("hs_tone_en", int'(tone_en_a), 1);
        chk("hs_freq", int'(freq_out_a), ef);
    endtask

    // measure tone and gap length, optionally pulsing stop/start in a given tone cycle
    task automatic run_tone(input int stop_at, input int start_at);
        int n = 0, g = 0;
        while (tone_en_a && n < 100) begin
            n++;
            stop_a  = n == stop_at;
            start_a = n == start_at;
            @(negedge clk);
        end
        stop_a  = 1'b0;
        start_a = 1'b0;
        chk("tone_len", n, 8);
        while (!rnd_req_a && busy_a && g < 100) begin
            g++;
            @(negedge clk);
        end
        chk("gap_len", g, 2);
    endtask

    // scoreboard consumer: every sec pulse pops one expected tone
    always @(negedge clk) begin
        if (rst_a) begin
            if (cnt_due) begin
                chk("tone_cnt", int'(tone_cnt_a), cnt_exp_m);
                cnt_due = 0;
            end
            if (sec_a) begin
                if (sbq.size() == 0) chk("sec_unexp", 1, 0);
                else begin
                    e_m = sbq.pop_front();
                    chk("sec_freq", int'(freq_out_a), e_m.f);
                    chk("sec_tone_en", int'(tone_en_a), 1);
                    cnt_exp_m = e_m.c;
                    cnt_due   = 1;
                end
            end
        end
    end

    initial begin
        int bad, h, l, secs, cyc;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("rst_freq", int'(freq_out_a), 0);
        chk("rst_tone_en", int'(tone_en_a), 0);
        chk("rst_req", int'(rnd_req_a), 0);
        chk("rst_sec", int'(sec_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_cnt", int'(tone_cnt_a), 0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy_a), 0);

        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("start_req", int'(rnd_req_a), 1);
        chk("start_busy", int'(busy_a), 1);
        accept(1000, 1000);
        run_tone(0, 0);
        chk("req_again", int'(rnd_req_a), 1);
        accept(50, 100);
        run_tone(0, 0);
        accept(4000, 3000);
        run_tone(0, 0);

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rnd_req_a || tone_en_a || sec_a) bad++;
        end
        chk("req_hold", bad, 0);

        accept(2000, 2000);
        run_tone(3, 0);
        chk("stop_busy", int'(busy_a), 0);
        chk("stop_req", int'(rnd_req_a), 0);
        rnd_valid_a = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rnd_req_a || tone_en_a || busy_a) bad++;
        end
        chk("idle_quiet", bad, 0);
        rnd_valid_a = 1'b0;

        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("req2", int'(rnd_req_a), 1);
        rnd_valid_a = 1'b1;
        rnd_freq_a  = 12'd500;
        stop_a      = 1'b1;
        @(negedge clk);
        stop_a      = 1'b0;
        rnd_valid_a = 1'b0;
        chk("reqstop_req", int'(rnd_req_a), 0);
        chk("reqstop_busy", int'(busy_a), 0);
        chk("reqstop_tone", int'(tone_en_a), 0);
        chk("reqstop_freq", int'(freq_out_a), 2000);

        start_a = 1'b1;
        stop_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        stop_a  = 1'b0;
        @(negedge clk);
        chk("startstop_busy", int'(busy_a), 0);
        chk("startstop_req", int'(rnd_req_a), 0);

        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        accept(1234, 1234);
        run_tone(0, 4);
        chk("busy_start_req", int'(rnd_req_a), 1);
        chk("busy_start_busy", int'(busy_a), 1);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        chk("final_busy", int'(busy_a), 0);
        @(negedge clk);
        chk("sb_empty", sbq.size(), 0);

        rnd_valid_b = 1'b1;
        rnd_freq_b  = 12'd500;
        start_b     = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            while (!tone_en_b && cyc < 50) begin
                cyc++;
                @(negedge clk);
            end
            h = 0;
            while (tone_en_b && h < 100) begin
                h++;
                @(negedge clk);
            end
            chk("b_tone_len", h, 8);
            l = 0;
            while (!tone_en_b && l < 100) begin
                l++;
                @(negedge clk);
            end
            chk("b_low_len", l, 1);
        end
        chk("b_cnt3", int'(tone_cnt_b), 3);
        chk("b_freq", int'(freq_out_b), 500);
        secs = 3;
        cyc  = 0;
        while (secs < 300 && cyc < 5000) begin
            if (sec_b) secs++;
            @(negedge clk);
            cyc++;
        end
        chk("b_secs", secs, 300);
        chk("b_wrap", int'(tone_cnt_b), 44);
        @(negedge clk);
        @(negedge clk);
        chk("b_pre_rst_tone", int'(tone_en_b), 1);
        #2 rst_b = 1'b0;
        #1;
        chk("b_async_tone", int'(tone_en_b), 0);
        chk("b_async_busy", int'(busy_b), 0);
        chk("b_async_cnt", int'(tone_cnt_b), 0);
        chk("b_async_freq", int'(freq_out_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
